note_source_arbiter: RTL and testbench

Shares the single tone-generator channel between the live keyboard and the automatic song player. Live play always has priority: it preempts a running song, and the song player is frozen through `song_hold` until the channel is released. An enforced silent gap separates every change of source, and a release filter keeps key chatter from bouncing ownership. The block sits between the key scanner / song player and the buzzer tone generator.

---
 rtl/note_source_arbiter_pkg.sv | 37 +++
 rtl/note_source_arbiter_if.sv | 28 ++
 rtl/note_source_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_note_source_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/note_source_arbiter_pkg.sv
// Shared piano definitions: note type, owner encodings, clock-derived timing defaults.
package note_source_arbiter_pkg;

  // System clock frequency the default cycle counts are derived from.
  localparam int unsigned CLK_HZ = 32'd100_000_000;

  // 50 ms of silence between owners, 20 ms of key release filtering.
  localparam int unsigned GAP_CYCLES_DFLT     = CLK_HZ / 32'd20;
  localparam int unsigned RELEASE_CYCLES_DFLT = CLK_HZ / 32'd50;

  // Note index handed to the tone generator.
  typedef logic [3:0] note_t;

  // Channel owner encoding.
  typedef logic [1:0] src_t;
  localparam src_t SRC_NONE = 2'd0;
  localparam src_t SRC_LIVE = 2'd1;
  localparam src_t SRC_SONG = 2'd2;

  // Side a silent gap was heading towards when it started.
  typedef enum logic {
    TGT_LIVE = 1'b0,
    TGT_SONG = 1'b1
  } gap_tgt_t;

  // Saturating 8-bit increment.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/note_source_arbiter_if.sv
// Bus between key scanner / song player (master side) and the source arbiter (slave side).
interface note_source_arbiter_if;
  import note_source_arbiter_pkg::*;

  logic       live_valid;
  note_t      live_key;
  logic       song_req;
  logic       song_key_on;
  note_t      song_key;
  logic       pause;

  logic       tone_on;
  note_t      tone_key;
  src_t       src;
  logic       song_hold;
  logic [7:0] preempt_cnt;

  modport master (
    output live_valid, live_key, song_req, song_key_on, song_key, pause,
    input  tone_on, tone_key, src, song_hold, preempt_cnt
  );

  modport slave (
    input  live_valid, live_key, song_req, song_key_on, song_key, pause,
    output tone_on, tone_key, src, song_hold, preempt_cnt
  );

endinterface

// File: rtl/note_source_arbiter.sv
// Shares the tone channel between live keys and the song player.
// Live play wins, every owner change passes through a silent gap, and
// live ownership is only dropped after a filtered release period.
module note_source_arbiter
  import note_source_arbiter_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = GAP_CYCLES_DFLT,
  parameter int unsigned RELEASE_CYCLES = RELEASE_CYCLES_DFLT
) (
  input logic                  clk,
  input logic                  rst,
  note_source_arbiter_if.slave io_bus
);

  localparam int unsigned CNT_MAX = (GAP_CYCLES > RELEASE_CYCLES) ? GAP_CYCLES : RELEASE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 32'd1);

  // Gap ends after GAP_CYCLES silent cycles; release fires on the sample
  // after RELEASE_CYCLES consecutive low samples have been counted.
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_LIVE = 2'd2,
    ST_SONG = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  gap_tgt_t         r_gap_tgt;
  logic             r_tone_on;
  note_t            r_tone_key;
  src_t             r_src;
  logic             r_song_hold;
  logic [7:0]       r_preempt_cnt;

  state_t           w_next_state;
  logic [CNT_W-1:0] w_cnt_run;
  logic [CNT_W-1:0] w_cnt_next;
  gap_tgt_t         w_gap_tgt_next;
  logic             w_preempt;
  logic             w_tone_on;
  note_t            w_tone_key;
  src_t             w_src;
  logic             w_song_hold;
  logic             w_unused_gap_tgt;

  // Owner choice from silence: live first, then a requesting song.
  function automatic state_t pick_owner(input logic live, input logic song);
    state_t s;
    if (live) begin
      s = ST_LIVE;
    end else if (song) begin
      s = ST_SONG;
    end else begin
      s = ST_IDLE;
    end
    return s;
  endfunction

  // The gap target is only a record of where the gap was heading; the end
  // of the gap re-reads the live requests so withdrawn requests are dropped.
  assign w_unused_gap_tgt = (r_gap_tgt == TGT_LIVE);

  // Next-state, counter and preemption decisions.
  always_comb begin
    w_next_state   = r_state;
    w_cnt_run      = r_cnt;
    w_gap_tgt_next = r_gap_tgt;
    w_preempt      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next_state = pick_owner(io_bus.live_valid, io_bus.song_req);
      end
      ST_LIVE: begin
        if (io_bus.live_valid) begin
          w_cnt_run = {CNT_W{1'b0}};
        end else if (r_cnt == REL_LAST) begin
          if (io_bus.song_req) begin
            w_next_state   = ST_GAP;
            w_gap_tgt_next = TGT_SONG;
          end else begin
            w_next_state = ST_IDLE;
          end
        end else begin
          w_cnt_run = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_SONG: begin
        if (io_bus.live_valid) begin
          w_next_state   = ST_GAP;
          w_gap_tgt_next = TGT_LIVE;
          w_preempt      = 1'b1;
        end else if (!io_bus.song_req) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_SONG;
        end
      end
      ST_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_next_state = pick_owner(io_bus.live_valid, io_bus.song_req);
        end else begin
          w_cnt_run = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
    if (w_next_state != r_state) begin
      w_cnt_next = {CNT_W{1'b0}};
    end else begin
      w_cnt_next = w_cnt_run;
    end
  end

  // Output values for the state being entered, so they land with it.
  always_comb begin
    w_tone_on   = 1'b0;
    w_tone_key  = r_tone_key;
    w_src       = SRC_NONE;
    w_song_hold = 1'b0;
    case (w_next_state)
      ST_LIVE: begin
        w_tone_on   = io_bus.live_valid;
        w_tone_key  = io_bus.live_key;
        w_src       = SRC_LIVE;
        w_song_hold = io_bus.song_req;
      end
      ST_SONG: begin
        w_tone_on   = io_bus.song_key_on & ~io_bus.pause;
        w_tone_key  = io_bus.song_key;
        w_src       = SRC_SONG;
        w_song_hold = io_bus.pause;
      end
      ST_GAP: begin
        w_song_hold = io_bus.song_req;
      end
      ST_IDLE: begin
        w_song_hold = 1'b0;
      end
      default: begin
        w_song_hold = 1'b0;
      end
    endcase
  end

  // State, shared counter, preemption count and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= {CNT_W{1'b0}};
      r_gap_tgt     <= TGT_LIVE;
      r_tone_on     <= 1'b0;
      r_tone_key    <= 4'd0;
      r_src         <= SRC_NONE;
      r_song_hold   <= 1'b0;
      r_preempt_cnt <= 8'd0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_cnt_next;
      r_gap_tgt   <= w_gap_tgt_next;
      r_tone_on   <= w_tone_on;
      r_tone_key  <= w_tone_key;
      r_src       <= w_src;
      r_song_hold <= w_song_hold;
      if (w_preempt) begin
        r_preempt_cnt <= sat_inc8(r_preempt_cnt);
      end else begin
        r_preempt_cnt <= r_preempt_cnt;
      end
    end
  end

  assign io_bus.tone_on     = r_tone_on;
  assign io_bus.tone_key    = r_tone_key;
  assign io_bus.src         = r_src;
  assign io_bus.song_hold   = r_song_hold;
  assign io_bus.preempt_cnt = r_preempt_cnt;

endmodule

// File: tb/tb_note_source_arbiter.sv
// Directed bench for note_source_arbiter with GAP_CYCLES=4, RELEASE_CYCLES=3.
module tb_note_source_arbiter;

  logic clk;
  logic rst;

  note_source_arbiter_if bus_if ();

  note_source_arbiter #(
    .GAP_CYCLES     (4),
    .RELEASE_CYCLES (3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       on;
    logic [3:0] key;
    logic [1:0] src;
    logic       hold;
    logic [7:0] pc;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_pc = 8'd0;

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic on, input logic [3:0] key,
                      input logic [1:0] s, input logic hold);
    exp_t e;
    e.tag  = tag;
    e.on   = on;
    e.key  = key;
    e.src  = s;
    e.hold = hold;
    e.pc   = exp_pc;
    q.push_back(e);
  endtask

  task automatic check_q();
    exp_t e;
    while (q.size() != 0) begin
      e = q.pop_front();
      cmp({e.tag, "/tone_on"},   {7'd0, bus_if.tone_on},   {7'd0, e.on});
      cmp({e.tag, "/tone_key"},  {4'd0, bus_if.tone_key},  {4'd0, e.key});
      cmp({e.tag, "/src"},       {6'd0, bus_if.src},       {6'd0, e.src});
      cmp({e.tag, "/song_hold"}, {7'd0, bus_if.song_hold}, {7'd0, e.hold});
      cmp({e.tag, "/preempt"},   bus_if.preempt_cnt,       e.pc);
    end
  endtask

  task automatic tick_check();
    @(posedge clk);
    #1;
    check_q();
  endtask

  task automatic step(input string tag, input logic on, input logic [3:0] key,
                      input logic [1:0] s, input logic hold);
    push(tag, on, key, s, hold);
    tick_check();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst                = 1'b1;
    bus_if.live_valid  = 1'b0;
    bus_if.live_key    = 4'd0;
    bus_if.song_req    = 1'b0;
    bus_if.song_key_on = 1'b0;
    bus_if.song_key    = 4'd0;
    bus_if.pause       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push("reset", 1'b0, 4'd0, 2'd0, 1'b0);
    check_q();
    rst = 1'b0;

    // Idle to live, then key change without gap.
    bus_if.live_valid = 1'b1;
    bus_if.live_key   = 4'd5;
    step("idle_live", 1'b1, 4'd5, 2'd1, 1'b0);
    bus_if.live_key = 4'd7;
    step("key_chg", 1'b1, 4'd7, 2'd1, 1'b0);

    // Release with no song waiting: straight to idle.
    bus_if.live_valid = 1'b0;
    for (int i = 0; i < 3; i++) step("rel_live", 1'b0, 4'd7, 2'd1, 1'b0);
    step("rel_idle", 1'b0, 4'd7, 2'd0, 1'b0);

    // Song starts from idle.
    bus_if.song_req    = 1'b1;
    bus_if.song_key_on = 1'b1;
    bus_if.song_key    = 4'd2;
    step("song", 1'b1, 4'd2, 2'd2, 1'b0);

    // Preemption by live key 9.
    bus_if.live_valid = 1'b1;
    bus_if.live_key   = 4'd9;
    exp_pc = 8'd1;
    step("pre_mute", 1'b0, 4'd2, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) step("pre_gap", 1'b0, 4'd2, 2'd0, 1'b1);
    step("pre_live", 1'b1, 4'd9, 2'd1, 1'b1);

    // Release to song, with a one-cycle glitch restarting the window.
    bus_if.live_valid = 1'b0;
    for (int i = 0; i < 2; i++) step("rel_pre", 1'b0, 4'd9, 2'd1, 1'b1);
    bus_if.live_valid = 1'b1;
    step("glitch", 1'b1, 4'd9, 2'd1, 1'b1);
    bus_if.live_valid = 1'b0;
    for (int i = 0; i < 3; i++) step("rel_win", 1'b0, 4'd9, 2'd1, 1'b1);
    for (int i = 0; i < 4; i++) step("rel_gap", 1'b0, 4'd9, 2'd0, 1'b1);
    step("rel_song", 1'b1, 4'd2, 2'd2, 1'b0);

    // Pause mutes and holds the song.
    bus_if.pause = 1'b1;
    step("pause", 1'b0, 4'd2, 2'd2, 1'b1);

    // Live preempts while paused.
    bus_if.live_valid = 1'b1;
    bus_if.live_key   = 4'd4;
    exp_pc = 8'd2;
    step("pause_pre", 1'b0, 4'd2, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) step("pause_gap", 1'b0, 4'd2, 2'd0, 1'b1);
    step("pause_live", 1'b1, 4'd4, 2'd1, 1'b1);
    bus_if.live_valid = 1'b0;
    for (int i = 0; i < 3; i++) step("p_rel_win", 1'b0, 4'd4, 2'd1, 1'b1);
    for (int i = 0; i < 4; i++) step("p_rel_gap", 1'b0, 4'd4, 2'd0, 1'b1);
    step("back_paused", 1'b0, 4'd2, 2'd2, 1'b1);
    bus_if.pause = 1'b0;
    step("unpause", 1'b1, 4'd2, 2'd2, 1'b0);

    // Song withdrawn during a live-target gap with live also gone: idle.
    bus_if.live_valid = 1'b1;
    bus_if.live_key   = 4'd6;
    exp_pc = 8'd3;
    step("wd_pre", 1'b0, 4'd2, 2'd0, 1'b1);
    bus_if.live_valid = 1'b0;
    bus_if.song_req   = 1'b0;
    for (int i = 0; i < 4; i++) step("wd_gap", 1'b0, 4'd2, 2'd0, 1'b0);
    bus_if.song_req = 1'b1;
    step("wd_idle_song", 1'b1, 4'd2, 2'd2, 1'b0);

    // Saturation: 300 further preemptions.
    for (int n = 0; n < 300; n++) begin
      bus_if.live_valid = 1'b1;
      tick_check();
      bus_if.live_valid = 1'b0;
      repeat (4) tick_check();
    end
    exp_pc = 8'd255;
    step("sat", 1'b1, 4'd2, 2'd2, 1'b0);

    // Asynchronous reset mid-note.
    rst = 1'b1;
    #1;
    exp_pc = 8'd0;
    push("async_rst", 1'b0, 4'd0, 2'd0, 1'b0);
    check_q();
    bus_if.song_req    = 1'b0;
    bus_if.song_key_on = 1'b0;
    tick_check();
    rst = 1'b0;
    step("post_rst", 1'b0, 4'd0, 2'd0, 1'b0);

    // Live during a song-target gap does not restart it and wins after.
    bus_if.live_valid  = 1'b1;
    bus_if.live_key    = 4'd1;
    bus_if.song_req    = 1'b1;
    bus_if.song_key_on = 1'b1;
    step("sg_live", 1'b1, 4'd1, 2'd1, 1'b1);
    bus_if.live_valid = 1'b0;
    for (int i = 0; i < 3; i++) step("sg_win", 1'b0, 4'd1, 2'd1, 1'b1);
    step("sg_gap0", 1'b0, 4'd1, 2'd0, 1'b1);
    bus_if.live_valid = 1'b1;
    bus_if.live_key   = 4'd8;
    for (int i = 0; i < 3; i++) step("sg_gap", 1'b0, 4'd1, 2'd0, 1'b1);
    step("sg_live_wins", 1'b1, 4'd8, 2'd1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
